// File: rtl/alu_issue_queue_pkg.sv
// Shared types and defaults for the ALU issue queue: uop bundle, queue
// entry, default geometry and the serial-op predicate.
package alu_issue_queue_pkg;

   localparam int IQ_DEPTH = 8;
   localparam int PRF_AW   = 6;
   localparam int ROB_W    = 6;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11,
      ALU_CP0  = 4'd12
   } alu_type_e;

   // Renamed uop as delivered by dispatch and handed to the ALUs.
   typedef struct packed {
      logic              valid;
      alu_type_e         alu_type;
      logic              op0_re;
      logic [PRF_AW-1:0] op0_paddr;
      logic              op1_re;
      logic [PRF_AW-1:0] op1_paddr;
      logic              dst_we;
      logic [PRF_AW-1:0] dst_paddr;
      logic [ROB_W-1:0]  rob_idx;
   } UOPBundle;

   // One queue slot: the uop plus per-source readiness.
   typedef struct packed {
      UOPBundle uop;
      logic     rdy0;
      logic     rdy1;
   } AluIQEntry;

   // CP0 moves must execute in program order and alone on ALU0.
   function automatic logic is_serial_op(input alu_type_e t);
      return t == ALU_CP0;
   endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch/wakeup/issue port bundle of the ALU issue queue.
//
// Handshake: dispatch presents enq_valid[1:0] with enq_uop; a slot is taken
// on a rising edge only when enq_ready was 1 in that cycle (enq_ready already
// guarantees room for two, so both slots are always accepted together).
// When enq_ready is 0 dispatch holds its uops and enq_valid is ignored.
// Issue outputs have no ready: the ALUs accept every cycle, and the valid
// field inside iss0_uop/iss1_uop qualifies the rest of the bundle.
interface alu_issue_queue_if
   import alu_issue_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) ();

   logic                          flush;
   logic [1:0]                    enq_valid;
   UOPBundle [1:0]                enq_uop;
   logic [1:0]                    enq_op0_rdy;
   logic [1:0]                    enq_op1_rdy;
   logic                          enq_ready;
   logic [3:0]                    wb_wen;
   logic [3:0][PRF_AW-1:0]        wb_tag;
   UOPBundle                      iss0_uop;
   UOPBundle                      iss1_uop;
   logic [$clog2(DEPTH):0]        occupancy;

   modport master (
      output flush, enq_valid, enq_uop, enq_op0_rdy, enq_op1_rdy,
      output wb_wen, wb_tag,
      input  enq_ready, iss0_uop, iss1_uop, occupancy
   );

   modport slave (
      input  flush, enq_valid, enq_uop, enq_op0_rdy, enq_op1_rdy,
      input  wb_wen, wb_tag,
      output enq_ready, iss0_uop, iss1_uop, occupancy
   );

endinterface

// File: rtl/alu_iq_select.sv
// Two-oldest priority picker. Index 0 is the oldest entry. A serial op may
// only be picked from index 0; when it is, the second grant is suppressed.
module alu_iq_select #(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0] elig,
   input  logic [DEPTH-1:0] serial,
   output logic [DEPTH-1:0] gnt0,
   output logic [DEPTH-1:0] gnt1
);

   logic [DEPTH-1:0] cand;
   logic             found0;
   logic             found1;
   logic             block1;

   // Scan oldest to youngest, handing out ALU0 then ALU1.
   always_comb begin
      gnt0   = '0;
      gnt1   = '0;
      found0 = 1'b0;
      found1 = 1'b0;
      block1 = 1'b0;
      cand   = elig & ~{serial[DEPTH-1:1], 1'b0};
      for (int i = 0; i < DEPTH; i++) begin
         if (cand[i]) begin
            if (!found0) begin
               gnt0[i] = 1'b1;
               found0  = 1'b1;
               if (i == 0 && serial[0]) begin
                  block1 = 1'b1;
               end
            end else if (!found1 && !block1) begin
               gnt1[i] = 1'b1;
               found1  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_issue_queue.sv
// Out-of-order issue queue for the two integer ALUs.
// Age-ordered, compacting queue: index 0 is oldest. Up to two uops enqueue
// and up to two issue per cycle; tag wakeups set per-source ready bits.
// Optional feature macro: ALU_IQ_FAST_WAKEUP_EN -- selected producers also
// broadcast their destination tag in the select cycle.
module alu_issue_queue
   import alu_issue_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) (
   input logic              clk,
   input logic              rst,
   alu_issue_queue_if.slave iq
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(DEPTH);
`ifdef ALU_IQ_FAST_WAKEUP_EN
   localparam int NWK = 6;
`else
   localparam int NWK = 4;
`endif

   AluIQEntry                ent_q [DEPTH];
   AluIQEntry                ent_d [DEPTH];
   logic [CW-1:0]            count_q;
   logic [CW-1:0]            count_d;
   UOPBundle                 iss0_q, iss1_q;
   UOPBundle                 iss0_d, iss1_d;
   logic [DEPTH-1:0]         elig, serial, gnt0, gnt1;
   logic [NWK-1:0]           wk_en;
   logic [NWK-1:0][PRF_AW-1:0] wk_tag;
   logic [CW-1:0]            issued_cnt;
   logic                     enq_ok;
   logic [CW-1:0]            shift;
   logic [CW-1:0]            dst;
   logic [CW-1:0]            pos;
   AluIQEntry                moved;
   AluIQEntry                newe;

   // True when any active wakeup source carries this tag.
   function automatic logic woken(input logic [PRF_AW-1:0] tag,
                                  input logic [NWK-1:0] en,
                                  input logic [NWK-1:0][PRF_AW-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NWK; k++) begin
         if (en[k] && tags[k] == tag) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   // Room for two is judged on the current count only, ignoring issues.
   assign enq_ok       = (count_q <= CW'(DEPTH - 2));
   assign iq.enq_ready = enq_ok;
   assign iq.occupancy = count_q;
   assign iq.iss0_uop  = iss0_q;
   assign iq.iss1_uop  = iss1_q;
   assign issued_cnt   = CW'(|gnt0) + CW'(|gnt1);

   // Live entries whose stored ready bits are both set may be selected.
   always_comb begin
      elig   = '0;
      serial = '0;
      for (int i = 0; i < DEPTH; i++) begin
         elig[i]   = (CW'(i) < count_q) & ent_q[i].rdy0 & ent_q[i].rdy1;
         serial[i] = (CW'(i) < count_q) & is_serial_op(ent_q[i].uop.alu_type);
      end
   end

   alu_iq_select #(.DEPTH(DEPTH)) u_select (
      .elig   (elig),
      .serial (serial),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   // Mux the granted entries onto the issue ports; no grant issues zeros.
   always_comb begin
      iss0_d = '0;
      iss1_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (gnt0[i]) iss0_d = ent_q[i].uop;
         if (gnt1[i]) iss1_d = ent_q[i].uop;
      end
   end

   // Wakeup sources: four writeback ports, plus selected producers if fast.
   always_comb begin
      wk_en  = '0;
      wk_tag = '0;
      for (int k = 0; k < 4; k++) begin
         wk_en[k]  = iq.wb_wen[k];
         wk_tag[k] = iq.wb_tag[k];
      end
`ifdef ALU_IQ_FAST_WAKEUP_EN
      wk_en[4]  = iss0_d.valid & iss0_d.dst_we;
      wk_tag[4] = iss0_d.dst_paddr;
      wk_en[5]  = iss1_d.valid & iss1_d.dst_we;
      wk_tag[5] = iss1_d.dst_paddr;
`endif
   end

   // Compact survivors downward past issued slots, then append new uops.
   always_comb begin
      ent_d = ent_q;
      shift = '0;
      dst   = '0;
      moved = '0;
      newe  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q) begin
            if (gnt0[i] | gnt1[i]) begin
               shift = shift + CW'(1);
            end else begin
               moved      = ent_q[i];
               moved.rdy0 = moved.rdy0 | woken(moved.uop.op0_paddr, wk_en, wk_tag);
               moved.rdy1 = moved.rdy1 | woken(moved.uop.op1_paddr, wk_en, wk_tag);
               dst        = CW'(i) - shift;
               ent_d[dst[IW-1:0]] = moved;
            end
         end
      end
      pos = count_q - issued_cnt;
      for (int s = 0; s < 2; s++) begin
         if (enq_ok && iq.enq_valid[s]) begin
            newe.uop       = iq.enq_uop[s];
            newe.uop.valid = 1'b1;
            newe.rdy0      = ~newe.uop.op0_re | iq.enq_op0_rdy[s]
                             | woken(newe.uop.op0_paddr, wk_en, wk_tag);
            newe.rdy1      = ~newe.uop.op1_re | iq.enq_op1_rdy[s]
                             | woken(newe.uop.op1_paddr, wk_en, wk_tag);
            ent_d[pos[IW-1:0]] = newe;
            pos = pos + CW'(1);
         end
      end
      count_d = pos;
   end

   // State update; flush drops everything, including same-cycle enq/issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         iss0_q  <= '0;
         iss1_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else if (iq.flush) begin
         count_q <= '0;
         iss0_q  <= '0;
         iss1_q  <= '0;
      end else begin
         count_q <= count_d;
         ent_q   <= ent_d;
         iss0_q  <= iss0_d;
         iss1_q  <= iss1_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed table of cycles with hand-derived
// expectations, then randomized traffic against a queue-based reference.
module tb_alu_issue_queue;
   import alu_issue_queue_pkg::*;

   localparam int DEPTH = IQ_DEPTH;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   alu_issue_queue_if #(.DEPTH(DEPTH)) iq_if ();

   alu_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .iq  (iq_if)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [1:0]        ev;
      UOPBundle          u0;
      UOPBundle          u1;
      logic [3:0]        wen;
      logic [PRF_AW-1:0] wtag;
      logic              fl;
      int                occ;
      logic              rdy;
      logic              v0;
      int                rob0;
      logic              v1;
      int                rob1;
   } vec_t;

   vec_t vecs[$];

   function automatic UOPBundle mk_uop(int rob, alu_type_e ty, bit re0, int t0,
                                       bit re1, int t1, bit dwe, int dt);
      UOPBundle u;
      u           = '0;
      u.valid     = 1'b1;
      u.alu_type  = ty;
      u.op0_re    = re0;
      u.op0_paddr = PRF_AW'(t0);
      u.op1_re    = re1;
      u.op1_paddr = PRF_AW'(t1);
      u.dst_we    = dwe;
      u.dst_paddr = PRF_AW'(dt);
      u.rob_idx   = ROB_W'(rob);
      return u;
   endfunction

   function automatic UOPBundle cons(int rob, int tag, int dt);
      return mk_uop(rob, ALU_ADD, 1'b1, tag, 1'b0, 0, 1'b1, dt);
   endfunction

   function automatic UOPBundle rop(int rob, alu_type_e ty, int dt);
      return mk_uop(rob, ty, 1'b0, 0, 1'b0, 0, 1'b1, dt);
   endfunction

   function automatic vec_t row(logic [1:0] ev, UOPBundle u0, UOPBundle u1,
                                logic [3:0] wen, int wtag, logic fl, int occ,
                                logic rdy, logic v0, int rob0, logic v1, int rob1);
      vec_t v;
      v.ev = ev;  v.u0 = u0;  v.u1 = u1;  v.wen = wen;  v.wtag = PRF_AW'(wtag);
      v.fl = fl;  v.occ = occ; v.rdy = rdy;
      v.v0 = v0;  v.rob0 = rob0; v.v1 = v1; v.rob1 = rob1;
      return v;
   endfunction

   function automatic vec_t idle(int occ, logic rdy, logic v0, int rob0, logic v1, int rob1);
      return row(2'b00, '0, '0, 4'b0000, 0, 1'b0, occ, rdy, v0, rob0, v1, rob1);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      iq_if.flush       = 1'b0;
      iq_if.enq_valid   = 2'b00;
      iq_if.enq_uop[0]  = '0;
      iq_if.enq_uop[1]  = '0;
      iq_if.enq_op0_rdy = 2'b00;
      iq_if.enq_op1_rdy = 2'b00;
      iq_if.wb_wen      = 4'b0000;
      for (int k = 0; k < 4; k++) iq_if.wb_tag[k] = '0;
   endtask

   task automatic apply_row(input int r, input vec_t v);
      drive_idle();
      iq_if.enq_valid  = v.ev;
      iq_if.enq_uop[0] = v.u0;
      iq_if.enq_uop[1] = v.u1;
      iq_if.wb_wen     = v.wen;
      for (int k = 0; k < 4; k++) iq_if.wb_tag[k] = v.wen[k] ? v.wtag : '0;
      iq_if.flush      = v.fl;
      @(posedge clk);
      #1;
      check($sformatf("row%0d occupancy", r), 64'(iq_if.occupancy), 64'(v.occ));
      check($sformatf("row%0d enq_ready", r), 64'(iq_if.enq_ready), 64'(v.rdy));
      check($sformatf("row%0d iss0", r),
            64'({iq_if.iss0_uop.valid, iq_if.iss0_uop.rob_idx}),
            64'({v.v0, ROB_W'(v.v0 ? v.rob0 : 0)}));
      check($sformatf("row%0d iss1", r),
            64'({iq_if.iss1_uop.valid, iq_if.iss1_uop.rob_idx}),
            64'({v.v1, ROB_W'(v.v1 ? v.rob1 : 0)}));
   endtask

   function automatic UOPBundle rand_uop();
      UOPBundle u;
      u           = '0;
      u.valid     = 1'($urandom);
      u.alu_type  = ($urandom_range(0, 15) == 0) ? ALU_CP0 : alu_type_e'($urandom_range(0, 11));
      u.op0_re    = 1'($urandom);
      u.op0_paddr = PRF_AW'($urandom_range(0, 15));
      u.op1_re    = 1'($urandom);
      u.op1_paddr = PRF_AW'($urandom_range(0, 15));
      u.dst_we    = 1'($urandom);
      u.dst_paddr = PRF_AW'($urandom_range(0, 15));
      u.rob_idx   = ROB_W'($urandom);
      return u;
   endfunction

   task automatic drive_random();
      rst               = ($urandom_range(0, 499) == 0);
      iq_if.flush       = ($urandom_range(0, 47) == 0);
      iq_if.enq_valid   = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
      iq_if.enq_uop[0]  = rand_uop();
      iq_if.enq_uop[1]  = rand_uop();
      iq_if.enq_op0_rdy = 2'($urandom);
      iq_if.enq_op1_rdy = 2'($urandom);
      for (int k = 0; k < 4; k++) begin
         iq_if.wb_wen[k] = ($urandom_range(0, 3) == 0);
         iq_if.wb_tag[k] = PRF_AW'($urandom_range(0, 15));
      end
   endtask

   // ---------------- reference model ----------------
   // Queue of waiting uops in program order; element 0 is the oldest.
   typedef struct {
      UOPBundle u;
      bit       r0;
      bit       r1;
   } m_ent_t;

   m_ent_t            mq[$];
   UOPBundle          m_iss0;
   UOPBundle          m_iss1;
   logic [PRF_AW-1:0] m_wt[8];
   int                m_nwt;

   function automatic bit woke(input logic [PRF_AW-1:0] t);
      for (int k = 0; k < m_nwt; k++) if (m_wt[k] == t) return 1'b1;
      return 1'b0;
   endfunction

   // Predict state and issue outputs after the coming clock edge.
   task automatic model_step();
      m_ent_t nq[$];
      m_ent_t e;
      int     a;
      int     b;
      bit     room;
      a = -1;
      b = -1;
      if (rst || iq_if.flush) begin
         mq.delete();
         m_iss0 = '0;
         m_iss1 = '0;
         return;
      end
      m_nwt = 0;
      for (int k = 0; k < 4; k++) begin
         if (iq_if.wb_wen[k]) begin
            m_wt[m_nwt] = iq_if.wb_tag[k];
            m_nwt++;
         end
      end
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].r0 && mq[i].r1 && (mq[i].u.alu_type != ALU_CP0 || i == 0)) begin
            if (a < 0) a = i;
            else if (b < 0 && mq[a].u.alu_type != ALU_CP0) b = i;
         end
      end
      m_iss0 = (a >= 0) ? mq[a].u : '0;
      m_iss1 = (b >= 0) ? mq[b].u : '0;
`ifdef ALU_IQ_FAST_WAKEUP_EN
      if (a >= 0 && mq[a].u.dst_we) begin m_wt[m_nwt] = mq[a].u.dst_paddr; m_nwt++; end
      if (b >= 0 && mq[b].u.dst_we) begin m_wt[m_nwt] = mq[b].u.dst_paddr; m_nwt++; end
`endif
      room = (DEPTH - mq.size()) >= 2;
      for (int i = 0; i < mq.size(); i++) begin
         if (i != a && i != b) begin
            e = mq[i];
            if (e.u.op0_re && woke(e.u.op0_paddr)) e.r0 = 1'b1;
            if (e.u.op1_re && woke(e.u.op1_paddr)) e.r1 = 1'b1;
            nq.push_back(e);
         end
      end
      for (int s = 0; s < 2; s++) begin
         if (room && iq_if.enq_valid[s]) begin
            e.u       = iq_if.enq_uop[s];
            e.u.valid = 1'b1;
            e.r0 = !e.u.op0_re || iq_if.enq_op0_rdy[s] || woke(e.u.op0_paddr);
            e.r1 = !e.u.op1_re || iq_if.enq_op1_rdy[s] || woke(e.u.op1_paddr);
            nq.push_back(e);
         end
      end
      mq = nq;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      m_nwt = 0;
      rst   = 1'b1;
      drive_idle();

      // Basic dual issue of two independent ADDs.
      vecs.push_back(row(2'b11, rop(1, ALU_ADD, 5), rop(2, ALU_ADD, 6), 4'b0000, 0, 1'b0, 2, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(0, 1'b1, 1'b1, 1, 1'b1, 2));
      vecs.push_back(idle(0, 1'b1, 1'b0, 0, 1'b0, 0));
      // Consumer of p9 woken later by the LSU port.
      vecs.push_back(row(2'b01, cons(3, 9, 10), '0, 4'b0000, 0, 1'b0, 1, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(1, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b00, '0, '0, 4'b0100, 9, 1'b0, 1, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(0, 1'b1, 1'b1, 3, 1'b0, 0));
      // Wakeup arriving in the same cycle as the consumer's enqueue.
      vecs.push_back(row(2'b01, cons(4, 9, 11), '0, 4'b0001, 9, 1'b0, 1, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(0, 1'b1, 1'b1, 4, 1'b0, 0));
      // Fill to DEPTH-1 with waiting uops; lone slot-1 packs; extras dropped.
      vecs.push_back(row(2'b11, cons(5, 20, 5), cons(6, 20, 6), 4'b0000, 0, 1'b0, 2, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b11, cons(7, 20, 7), cons(8, 20, 8), 4'b0000, 0, 1'b0, 4, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b11, cons(9, 20, 9), cons(10, 20, 10), 4'b0000, 0, 1'b0, 6, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b10, cons(40, 20, 40), cons(11, 20, 11), 4'b0000, 0, 1'b0, 7, 1'b0, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b11, rop(12, ALU_ADD, 12), rop(13, ALU_ADD, 13), 4'b0000, 0, 1'b0, 7, 1'b0, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b01, rop(12, ALU_ADD, 12), '0, 4'b0000, 0, 1'b0, 7, 1'b0, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b00, '0, '0, 4'b0010, 20, 1'b0, 7, 1'b0, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(5, 1'b1, 1'b1, 5, 1'b1, 6));
      vecs.push_back(idle(3, 1'b1, 1'b1, 7, 1'b1, 8));
      vecs.push_back(idle(1, 1'b1, 1'b1, 9, 1'b1, 10));
      vecs.push_back(idle(0, 1'b1, 1'b1, 11, 1'b0, 0));
      // Serial op at head issues alone on ALU0.
      vecs.push_back(row(2'b11, rop(14, ALU_CP0, 30), rop(15, ALU_ADD, 31), 4'b0000, 0, 1'b0, 2, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(1, 1'b1, 1'b1, 14, 1'b0, 0));
      vecs.push_back(idle(0, 1'b1, 1'b1, 15, 1'b0, 0));
      // Unready serial op at head lets a younger ready uop pass.
      vecs.push_back(row(2'b11, mk_uop(16, ALU_CP0, 1'b1, 21, 1'b0, 0, 1'b0, 0), rop(17, ALU_ADD, 32),
                         4'b0000, 0, 1'b0, 2, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(1, 1'b1, 1'b1, 17, 1'b0, 0));
      vecs.push_back(row(2'b00, '0, '0, 4'b1000, 21, 1'b0, 1, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(0, 1'b1, 1'b1, 16, 1'b0, 0));
      // Flush with three ready entries and a simultaneous dual enqueue.
      vecs.push_back(row(2'b11, cons(18, 22, 33), cons(19, 22, 34), 4'b0000, 0, 1'b0, 2, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b01, cons(20, 22, 35), '0, 4'b0000, 0, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b00, '0, '0, 4'b0001, 22, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(row(2'b11, rop(21, ALU_ADD, 36), rop(22, ALU_ADD, 37), 4'b0000, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 0));
      vecs.push_back(idle(0, 1'b1, 1'b0, 0, 1'b0, 0));

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset occupancy", 64'(iq_if.occupancy), 64'(0));
      check("reset enq_ready", 64'(iq_if.enq_ready), 64'(1));
      check("reset iss0", 64'(iq_if.iss0_uop), 64'(0));
      check("reset iss1", 64'(iq_if.iss1_uop), 64'(0));
      rst = 1'b0;

      for (int r = 0; r < vecs.size(); r++) apply_row(r, vecs[r]);

      // Re-synchronise DUT and model, then randomized traffic.
      drive_idle();
      rst = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      for (int c = 0; c < 3000; c++) begin
         drive_random();
         model_step();
         @(posedge clk);
         #1;
         check($sformatf("cyc%0d occupancy", c), 64'(iq_if.occupancy), 64'(mq.size()));
         check($sformatf("cyc%0d enq_ready", c), 64'(iq_if.enq_ready), 64'((DEPTH - mq.size()) >= 2));
         check($sformatf("cyc%0d iss0", c), 64'(iq_if.iss0_uop), 64'(m_iss0));
         check($sformatf("cyc%0d iss1", c), 64'(iq_if.iss1_uop), 64'(m_iss1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
